// File: rtl/avr_wait_arb_pkg.sv
// Shared definitions for the Z80<->AVR wait-channel arbiter:
// FSM state encoding, default read data and default timeout length.
package avr_wait_arb_pkg;

    typedef enum logic [1:0] {
        WA_IDLE    = 2'd0,
        WA_BUSY    = 2'd1,
        WA_RELEASE = 2'd2
    } wa_state_e;

    // Read data returned when an access completes without AVR data.
    localparam logic [7:0]  WA_RD_DEFAULT     = 8'hFF;
    // Default BUSY length before a forced completion.
    localparam logic [15:0] WA_TMO_CYCLES_DEF = 16'd60000;

    // Next round-robin index after idx, wrapping at n requesters.
    function automatic logic [1:0] wa_next_idx(input logic [1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/avr_wait_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of the
// pending mask at or after the pointer, searching upward and wrapping.
module avr_wait_arb_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] mask_i,
    input  logic [1:0]      ptr_i,
    output logic            vld_o,
    output logic [1:0]      idx_o
);

    // Scan offsets 0..NREQ-1 from the pointer; first hit wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!vld_o && mask_i[j] && (j == (int'(ptr_i) + k) % NREQ)) begin
                    vld_o = 1'b1;
                    idx_o = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/avr_wait_arb.sv
// Arbiter/sequencer for the single Z80<->AVR wait channel of the SPI slave.
// Requesters strobe req for one cycle; the Z80 is held in WAIT while any
// access is outstanding, accesses are served one at a time round-robin, and
// the AVR read data is returned on wait_end.
// Optional feature: define AVR_WAIT_TMO_EN to force completion of an access
// after TMO_CYCLES cycles in BUSY (rsp_data = 8'hFF, tmo_stb pulses).
module avr_wait_arb
    import avr_wait_arb_pkg::*;
#(
    parameter int          NREQ       = 2,
    parameter logic [15:0] TMO_CYCLES = WA_TMO_CYCLES_DEF
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_wdata,
    input  logic [NREQ-1:0]   req_rnw,
    output logic              wait_n,
    output logic [7:0]        wait_addr,
    output logic [7:0]        wait_write,
    output logic              wait_rnw,
    output logic [1:0]        wait_src,
    output logic              wait_pend,
    input  logic [7:0]        wait_read,
    input  logic              wait_end,
    output logic [7:0]        rsp_data,
    output logic [NREQ-1:0]   rsp_stb,
    output logic              tmo_stb
);

    wa_state_e                  state_q;
    logic [NREQ-1:0]            pending_q;
    logic [NREQ-1:0][7:0]       hold_addr_q;
    logic [NREQ-1:0][7:0]       hold_wdata_q;
    logic [NREQ-1:0]            hold_rnw_q;
    logic [1:0]                 rr_ptr_q;
    logic [7:0]                 wait_addr_q, wait_write_q, rsp_data_q;
    logic                       wait_rnw_q, wait_pend_q, tmo_stb_q;
    logic [1:0]                 wait_src_q;
    logic [NREQ-1:0]            rsp_stb_q;

    logic                       pick_vld;
    logic [1:0]                 pick_idx;
    logic [7:0]                 sel_addr, sel_wdata;
    logic                       sel_rnw;
    logic [NREQ-1:0]            src_oh;
    logic                       tmo_hit;

    avr_wait_arb_rr_pick #(.NREQ(NREQ)) rr_pick (
        .mask_i (pending_q),
        .ptr_i  (rr_ptr_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    // Mux the picked requester's holding registers; decode granted source.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_rnw   = 1'b1;
        src_oh    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == 2'(i)) begin
                sel_addr  = hold_addr_q[i];
                sel_wdata = hold_wdata_q[i];
                sel_rnw   = hold_rnw_q[i];
            end
            if (wait_src_q == 2'(i)) src_oh[i] = 1'b1;
        end
    end

`ifdef AVR_WAIT_TMO_EN
    logic [15:0] tmo_cnt_q;

    // Count BUSY cycles; terminal count forces completion.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WA_IDLE && pick_vld) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WA_BUSY) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign tmo_hit = (state_q == WA_BUSY) && (tmo_cnt_q == TMO_CYCLES - 16'd1);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    // Per-requester holding registers: a new strobe always overwrites.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_rnw_q   <= '1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    hold_addr_q[i]  <= req_addr[8*i +: 8];
                    hold_wdata_q[i] <= req_wdata[8*i +: 8];
                    hold_rnw_q[i]   <= req_rnw[i];
                end
            end
        end
    end

    // Grant/complete/release sequencer with registered channel outputs.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            state_q      <= WA_IDLE;
            pending_q    <= '0;
            rr_ptr_q     <= 2'd0;
            wait_addr_q  <= 8'h00;
            wait_write_q <= 8'h00;
            wait_rnw_q   <= 1'b1;
            wait_src_q   <= 2'd0;
            wait_pend_q  <= 1'b0;
            rsp_data_q   <= WA_RD_DEFAULT;
            rsp_stb_q    <= '0;
            tmo_stb_q    <= 1'b0;
        end else begin
            rsp_stb_q <= '0;
            tmo_stb_q <= 1'b0;
            case (state_q)
                WA_IDLE: begin
                    if (pick_vld) begin
                        wait_addr_q  <= sel_addr;
                        wait_write_q <= sel_wdata;
                        wait_rnw_q   <= sel_rnw;
                        wait_src_q   <= pick_idx;
                        wait_pend_q  <= 1'b1;
                        state_q      <= WA_BUSY;
                    end
                end
                WA_BUSY: begin
                    if (wait_end || tmo_hit) begin
                        rsp_data_q  <= wait_end ? wait_read : WA_RD_DEFAULT;
                        tmo_stb_q   <= ~wait_end;
                        rsp_stb_q   <= src_oh;
                        pending_q   <= pending_q & ~src_oh;
                        rr_ptr_q    <= wa_next_idx(wait_src_q, NREQ);
                        wait_pend_q <= 1'b0;
                        state_q     <= WA_RELEASE;
                    end
                end
                WA_RELEASE: state_q <= WA_IDLE;
                default:    state_q <= WA_IDLE;
            endcase
            // A new strobe sets pending even if the same source just completed.
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) pending_q[i] <= 1'b1;
            end
        end
    end

    assign wait_n     = ~(|req | |pending_q);
    assign wait_addr  = wait_addr_q;
    assign wait_write = wait_write_q;
    assign wait_rnw   = wait_rnw_q;
    assign wait_src   = wait_src_q;
    assign wait_pend  = wait_pend_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_stb    = rsp_stb_q;
    assign tmo_stb    = tmo_stb_q;

endmodule

// File: tb/tb_avr_wait_arb.sv
// Scoreboard bench for avr_wait_arb: stimulus pushes expected grants and
// responses into queues; monitors pop and compare when the DUT presents them.
module tb_avr_wait_arb;

    localparam int NREQ = 2;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       rnw;
        logic [1:0] src;
    } grant_t;

    typedef struct {
        logic [1:0] stb;
        logic [7:0] data;
        logic       tmo;
    } rsp_t;

    logic            fclk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req = '0;
    logic [7:0]      addr_v [2];
    logic [7:0]      wd_v   [2];
    logic [1:0]      rnw_v = 2'b11;
    logic [15:0]     req_addr, req_wdata;
    logic [7:0]      wait_read = 8'h00;
    logic            wait_end = 1'b0;
    logic            wait_n, wait_rnw, wait_pend, tmo_stb;
    logic [7:0]      wait_addr, wait_write, rsp_data;
    logic [1:0]      wait_src, rsp_stb;

    int checks = 0;
    int errors = 0;

    grant_t grant_q[$];
    rsp_t   rsp_q[$];
    grant_t cur_g;
    logic   pend_prev = 1'b0;

    assign req_addr  = {addr_v[1], addr_v[0]};
    assign req_wdata = {wd_v[1], wd_v[0]};

    always #5 fclk = ~fclk;

    avr_wait_arb #(.NREQ(NREQ), .TMO_CYCLES(16'd16)) dut (
        .fclk(fclk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rnw(rnw_v), .wait_n(wait_n),
        .wait_addr(wait_addr), .wait_write(wait_write), .wait_rnw(wait_rnw),
        .wait_src(wait_src), .wait_pend(wait_pend), .wait_read(wait_read),
        .wait_end(wait_end), .rsp_data(rsp_data), .rsp_stb(rsp_stb),
        .tmo_stb(tmo_stb)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic push_grant(input logic [7:0] a, input logic [7:0] w, input logic r, input logic [1:0] s);
        grant_t g;
        g.addr = a; g.wdata = w; g.rnw = r; g.src = s;
        grant_q.push_back(g);
    endtask

    task automatic push_rsp(input logic [1:0] stb, input logic [7:0] d, input logic t);
        rsp_t r;
        r.stb = stb; r.data = d; r.tmo = t;
        rsp_q.push_back(r);
    endtask

    // Poll until a grant is visible, bounded.
    task automatic wait_grant();
        for (int n = 0; n < 20; n++) begin
            if (wait_pend === 1'b1) break;
            tick();
        end
        chk("grant_seen", wait_pend, 1);
    endtask

    // Pulse wait_end for one cycle; returns at the response cycle.
    task automatic complete(input logic [1:0] stb, input logic [7:0] rd);
        wait_end = 1'b1;
        wait_read = rd;
        push_rsp(stb, rd, 1'b0);
        tick();
        wait_end = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge fclk);
        chk({tag, "_wait_n"}, wait_n, 1);
        chk({tag, "_wait_pend"}, wait_pend, 0);
        chk({tag, "_wait_src"}, wait_src, 0);
        chk({tag, "_wait_addr"}, wait_addr, 8'h00);
        chk({tag, "_wait_write"}, wait_write, 8'h00);
        chk({tag, "_wait_rnw"}, wait_rnw, 1);
        chk({tag, "_rsp_data"}, rsp_data, 8'hFF);
        chk({tag, "_rsp_stb"}, rsp_stb, 0);
        chk({tag, "_tmo_stb"}, tmo_stb, 0);
    endtask

    // Grant monitor: new grant on wait_pend rise, stability while it stays high.
    always @(negedge fclk) begin
        if (wait_pend === 1'b1 && pend_prev !== 1'b1) begin
            if (grant_q.size() == 0) begin
                chk("grant_unexpected", 1, 0);
            end else begin
                cur_g = grant_q.pop_front();
                chk("grant_addr", wait_addr, cur_g.addr);
                chk("grant_write", wait_write, cur_g.wdata);
                chk("grant_rnw", wait_rnw, cur_g.rnw);
                chk("grant_src", wait_src, cur_g.src);
            end
        end else if (wait_pend === 1'b1) begin
            chk("busy_addr_stable", wait_addr, cur_g.addr);
            chk("busy_write_stable", wait_write, cur_g.wdata);
            chk("busy_rnw_stable", wait_rnw, cur_g.rnw);
            chk("busy_src_stable", wait_src, cur_g.src);
        end
        pend_prev = wait_pend;
    end

    // Response monitor: any strobe must match the next expected response.
    always @(negedge fclk) begin
        rsp_t r;
        if (rsp_stb !== 2'b00 || tmo_stb !== 1'b0) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {rsp_stb, tmo_stb}, 0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_stb", rsp_stb, r.stb);
                chk("rsp_data", rsp_data, r.data);
                chk("rsp_tmo", tmo_stb, r.tmo);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        addr_v[0] = 8'h00; addr_v[1] = 8'h00;
        wd_v[0] = 8'h00;   wd_v[1] = 8'h00;
        repeat (3) tick();
        check_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Single read from requester 0.
        addr_v[0] = 8'h0C; wd_v[0] = 8'h00; rnw_v[0] = 1'b1;
        req = 2'b01;
        push_grant(8'h0C, 8'h00, 1'b1, 2'd0);
        @(negedge fclk);
        chk("rd_wait_n_c0", wait_n, 0);
        chk("rd_pend_c0", wait_pend, 0);
        tick();
        req = 2'b00;
        @(negedge fclk);
        chk("rd_wait_n_c1", wait_n, 0);
        chk("rd_pend_c1", wait_pend, 0);
        tick();
        @(negedge fclk);
        chk("rd_pend_c2", wait_pend, 1);
        tick();
        tick();
        complete(2'b01, 8'h5A);
        @(negedge fclk);
        chk("rd_wait_n_done", wait_n, 1);
        chk("rd_pend_done", wait_pend, 0);
        chk("rd_rsp_data", rsp_data, 8'h5A);
        tick();

        // Write from requester 1; monitor checks stability through BUSY.
        addr_v[1] = 8'hF7; wd_v[1] = 8'h33; rnw_v[1] = 1'b0;
        req = 2'b10;
        push_grant(8'hF7, 8'h33, 1'b0, 2'd1);
        tick();
        req = 2'b00;
        wait_grant();
        repeat (4) tick();
        complete(2'b10, 8'hA5);
        tick();

        // Contention: both at once, 0 first then 1.
        addr_v[0] = 8'h10; addr_v[1] = 8'h20; wd_v[0] = 8'h01; wd_v[1] = 8'h02;
        rnw_v = 2'b11;
        req = 2'b11;
        push_grant(8'h10, 8'h01, 1'b1, 2'd0);
        push_grant(8'h20, 8'h02, 1'b1, 2'd1);
        tick();
        req = 2'b00;
        wait_grant();
        tick();
        complete(2'b01, 8'h01);
        // Drop visible at N+1 and N+2, re-grant at N+3.
        @(negedge fclk);
        chk("cont_pend_n1", wait_pend, 0);
        chk("cont_wait_n_n1", wait_n, 0);
        tick();
        @(negedge fclk);
        chk("cont_pend_n2", wait_pend, 0);
        tick();
        @(negedge fclk);
        chk("cont_pend_n3", wait_pend, 1);
        chk("cont_src_n3", wait_src, 1);
        tick();
        complete(2'b10, 8'h02);
        tick();
        // Pointer wrapped to 0 after serving 1: 0 first again.
        addr_v[0] = 8'h30; addr_v[1] = 8'h40;
        req = 2'b11;
        push_grant(8'h30, 8'h01, 1'b1, 2'd0);
        push_grant(8'h40, 8'h02, 1'b1, 2'd1);
        tick();
        req = 2'b00;
        wait_grant();
        chk("cont2_first_src", wait_src, 0);
        complete(2'b01, 8'h03);
        wait_grant();
        complete(2'b10, 8'h04);
        tick();

        // Collision: requester 0 re-strobes in its own wait_end cycle.
        addr_v[0] = 8'h50; wd_v[0] = 8'h00; rnw_v[0] = 1'b1;
        req = 2'b01;
        push_grant(8'h50, 8'h00, 1'b1, 2'd0);
        tick();
        req = 2'b00;
        wait_grant();
        tick();
        addr_v[0] = 8'h11; wd_v[0] = 8'h22; rnw_v[0] = 1'b0;
        req = 2'b01;
        wait_end = 1'b1;
        wait_read = 8'h6C;
        push_rsp(2'b01, 8'h6C, 1'b0);
        push_grant(8'h11, 8'h22, 1'b0, 2'd0);
        tick();
        req = 2'b00;
        wait_end = 1'b0;
        @(negedge fclk);
        chk("coll_wait_n_held", wait_n, 0);
        chk("coll_rsp_stb", rsp_stb, 2'b01);
        wait_grant();
        chk("coll_regrant_addr", wait_addr, 8'h11);
        complete(2'b01, 8'h7E);
        tick();
        tick();

        // Stray wait_end while idle is ignored; outputs hold.
        wait_end = 1'b1;
        wait_read = 8'h77;
        tick();
        wait_end = 1'b0;
        @(negedge fclk);
        chk("stray_pend", wait_pend, 0);
        chk("stray_rsp_stb", rsp_stb, 0);
        chk("stray_rsp_data_hold", rsp_data, 8'h7E);
        chk("stray_addr_hold", wait_addr, 8'h11);
        tick();

`ifdef AVR_WAIT_TMO_EN
        // Timeout: no wait_end; completion 16 cycles after entering BUSY.
        addr_v[1] = 8'h66; wd_v[1] = 8'h00; rnw_v[1] = 1'b1;
        req = 2'b10;
        push_grant(8'h66, 8'h00, 1'b1, 2'd1);
        tick();
        req = 2'b00;
        wait_grant();
        push_rsp(2'b10, 8'hFF, 1'b1);
        repeat (15) tick();
        @(negedge fclk);
        chk("tmo_not_early", rsp_stb, 0);
        tick();
        @(negedge fclk);
        chk("tmo_stb", tmo_stb, 1);
        chk("tmo_rsp_stb", rsp_stb, 2'b10);
        chk("tmo_rsp_data", rsp_data, 8'hFF);
        tick();
        tick();
`endif

        // Reset mid-BUSY: access abandoned, no response.
        addr_v[0] = 8'h99; wd_v[0] = 8'h44; rnw_v[0] = 1'b0;
        req = 2'b01;
        push_grant(8'h99, 8'h44, 1'b0, 2'd0);
        tick();
        req = 2'b00;
        wait_grant();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("midrst");
        rst_n = 1'b1;
        tick();
        wait_end = 1'b1;
        wait_read = 8'h12;
        tick();
        wait_end = 1'b0;
        repeat (3) tick();
        @(negedge fclk);
        chk("post_rst_pend", wait_pend, 0);
        chk("post_rst_rsp_data", rsp_data, 8'hFF);

        chk("grant_q_drained", grant_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
